noc_vchannel_buffer_demux: RTL and testbench

Receive-side virtual-channel stage that sits directly downstream of the virtual-channel multiplexer and its link. It takes a single shared flit bus that carries a one-hot per-channel valid, and steers each flit into a per-channel FIFO. It exposes an independent valid/ready stream per virtual channel toward the router input or endpoint. Per-channel ready reflects only that channel's free space, so one blocked channel never stalls the others.

---
 rtl/noc_vchannel_pkg.sv | 20 ++
 rtl/noc_vchannel_fifo.sv | 83 ++++++++
 rtl/noc_vchannel_buffer_demux.sv | 74 +++++++
 tb/tb_noc_vchannel_buffer_demux.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/noc_vchannel_pkg.sv
// Shared definitions for the receive-side virtual-channel buffer demux.
// Width helpers and the {last, flit} storage entry layout.
package noc_vchannel_pkg;

    // Read/write pointer width; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width; must be able to hold the value depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // A stored entry is {last, flit}: the last marker sits in the MSB.
    function automatic int unsigned entry_width(input int unsigned flit_w);
        return flit_w + 1;
    endfunction

endpackage

// File: rtl/noc_vchannel_fifo.sv
// Single-channel first-word-fall-through FIFO holding {last, flit}.
// Depth need not be a power of two; pointers wrap by explicit compare.
module noc_vchannel_fifo
    import noc_vchannel_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH   = 32,
    parameter int unsigned BUFFER_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [FLIT_WIDTH-1:0] wr_flit,
    input  logic                  wr_last,
    output logic                  full,
    input  logic                  rd_en,
    output logic [FLIT_WIDTH-1:0] rd_flit,
    output logic                  rd_last,
    output logic                  empty
);

    localparam int unsigned PTR_W = ptr_width(BUFFER_DEPTH);
    localparam int unsigned CNT_W = cnt_width(BUFFER_DEPTH);
    localparam int unsigned ENT_W = entry_width(FLIT_WIDTH);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_DEPTH);

    logic [ENT_W-1:0] mem_q [BUFFER_DEPTH];
    logic [ENT_W-1:0] mem_d [BUFFER_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ENT_W-1:0] head;
    logic             wr_fire;
    logic             rd_fire;

    // Status comes from registered occupancy only.
    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign wr_fire = wr_en & ~full;
    assign rd_fire = rd_en & ~empty;

    // Head entry always visible on the read side.
    assign head    = mem_q[rd_ptr_q];
    assign rd_flit = head[FLIT_WIDTH-1:0];
    assign rd_last = head[FLIT_WIDTH];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire) begin
            mem_d[wr_ptr_q] = {wr_last, wr_flit};
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (wr_fire && !rd_fire) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_fire && rd_fire) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // State registers with synchronous reset of storage as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/noc_vchannel_buffer_demux.sv
// Steers a shared one-hot-valid flit bus into per-channel FIFOs.
// Each channel has its own valid/ready stream; no cross-channel stall.
module noc_vchannel_buffer_demux
    import noc_vchannel_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH   = 32,
    parameter int unsigned CHANNELS     = 7,
    parameter int unsigned BUFFER_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [FLIT_WIDTH-1:0]                in_flit,
    input  logic                                 in_last,
    input  logic [CHANNELS-1:0]                  in_valid,
    output logic [CHANNELS-1:0]                  in_ready,
    output logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  out_flit,
    output logic [CHANNELS-1:0]                  out_last,
    output logic [CHANNELS-1:0]                  out_valid,
    input  logic [CHANNELS-1:0]                  out_ready,
    output logic                                 err_onehot
);

    logic [CHANNELS-1:0] wr_en;
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] empty;
    logic                multi_hot;
    logic                err_q, err_d;

    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi_hot = |(in_valid & (in_valid - CHANNELS'(1)));

    // Write decode: a malformed valid vector writes nowhere.
    always_comb begin
        wr_en = multi_hot ? '0 : in_valid;
    end

    // Sticky protocol error flag.
    always_comb begin
        err_d = err_q | multi_hot;
    end

    // Error register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_onehot = err_q;

    for (genvar gi = 0; gi < int'(CHANNELS); gi++) begin : g_ch
        noc_vchannel_fifo #(
            .FLIT_WIDTH   (FLIT_WIDTH),
            .BUFFER_DEPTH (BUFFER_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[gi]),
            .wr_flit (in_flit),
            .wr_last (in_last),
            .full    (full[gi]),
            .rd_en   (out_ready[gi]),
            .rd_flit (out_flit[gi]),
            .rd_last (out_last[gi]),
            .empty   (empty[gi])
        );
    end

    assign in_ready  = ~full;
    assign out_valid = ~empty;

endmodule

// File: tb/tb_noc_vchannel_buffer_demux.sv
// Scoreboard bench for noc_vchannel_buffer_demux.
// Per-channel expected-flit queues, checked every cycle on the falling edge.
module tb_noc_vchannel_buffer_demux;

    localparam int CH = 7;
    localparam int FW = 32;
    localparam int D  = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [FW-1:0]          in_flit = '0;
    logic                   in_last = 1'b0;
    logic [CH-1:0]          in_valid = '0;
    logic [CH-1:0]          in_ready;
    logic [CH-1:0][FW-1:0]  out_flit;
    logic [CH-1:0]          out_last;
    logic [CH-1:0]          out_valid;
    logic [CH-1:0]          out_ready = '0;
    logic                   err_onehot;

    int tests = 0;
    int fails = 0;

    logic [FW:0] exp_q [CH][$];
    int          mcount [CH];
    bit          fresh [CH];
    bit          err_exp = 1'b0;

    noc_vchannel_buffer_demux #(
        .FLIT_WIDTH   (FW),
        .CHANNELS     (CH),
        .BUFFER_DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_flit    (in_flit),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_flit   (out_flit),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_onehot (err_onehot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int c,
                       input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s ch%0d got %0h want %0h at %0t",
                     n, c, act, exp, $time);
        end
    endtask

    // Reference model: FIFO queues per channel, capacity D.
    always @(posedge clk) begin
        bit multi;
        bit wr;
        bit rd;
        multi = ($countones(in_valid) > 1);
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                exp_q[c].delete();
                mcount[c] = 0;
                fresh[c]  = 1'b1;
            end
            err_exp = 1'b0;
        end else begin
            if (multi) err_exp = 1'b1;
            for (int c = 0; c < CH; c++) begin
                wr = !multi && in_valid[c] && (mcount[c] != D);
                rd = (mcount[c] != 0) && out_ready[c];
                if (wr) begin
                    exp_q[c].push_back({in_last, in_flit});
                    fresh[c] = 1'b0;
                end
                mcount[c] = mcount[c] + int'(wr) - int'(rd);
            end
        end
    end

    // Monitor: compare DUT outputs to the head of each expected queue.
    always @(negedge clk) begin
        logic [FW:0] h;
        for (int c = 0; c < CH; c++) begin
            chk("in_ready", c, 64'(in_ready[c]), 64'(exp_q[c].size() != D));
            chk("out_valid", c, 64'(out_valid[c]), 64'(exp_q[c].size() != 0));
            if (exp_q[c].size() != 0) begin
                h = exp_q[c][0];
                chk("out_flit", c, 64'(out_flit[c]), 64'(h[FW-1:0]));
                chk("out_last", c, 64'(out_last[c]), 64'(h[FW]));
                if (out_ready[c]) void'(exp_q[c].pop_front());
            end else if (fresh[c]) begin
                chk("rst_flit", c, 64'(out_flit[c]), 64'(0));
                chk("rst_last", c, 64'(out_last[c]), 64'(0));
            end
        end
        chk("err_onehot", 0, 64'(err_onehot), 64'(err_exp));
    end

    // Apply inputs for one clock edge, return just after it.
    task automatic cyc(input logic [CH-1:0] v, input logic [FW-1:0] f,
                       input logic l, input logic [CH-1:0] r);
        in_valid  = v;
        in_flit   = f;
        in_last   = l;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [CH-1:0] r);
        for (int i = 0; i < n; i++) cyc('0, '0, 1'b0, r);
    endtask

    initial begin
        logic [CH-1:0] v;
        logic [CH-1:0] r;
        int            k;

        rst = 1'b1;
        idle(2, '0);
        rst = 1'b0;
        idle(5, '0);

        // Single flit on channel 2, then popped.
        cyc(7'b0000100, 32'hDEAD_0001, 1'b1, '0);
        cyc('0, '0, 1'b0, 7'b0000100);
        idle(2, '0);

        // Fill channel 0, overflow write ignored, then drain in order.
        for (int i = 1; i <= D; i++) cyc(7'b0000001, FW'(i), i == D, '0);
        cyc(7'b0000001, 32'h5, 1'b0, '0);
        idle(2, '0);
        idle(D + 1, 7'b0000001);

        // Full channel with simultaneous write and read.
        for (int i = 1; i <= D; i++) cyc(7'b0000001, FW'(32'h10 + i), 1'b0, '0);
        cyc(7'b0000001, 32'h99, 1'b1, 7'b0000001);
        idle(2, '0);
        idle(D, 7'b0000001);

        // Channel 1 full and blocked; channels 3 and 5 stream past it.
        for (int i = 1; i <= D; i++) cyc(7'b0000010, FW'(32'h100 + i), 1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            v = (i % 2 == 1) ? 7'b0100000 : 7'b0001000;
            cyc(v, FW'(32'h300 + i), (i % 3) == 0, 7'b0101000);
        end
        idle(3, 7'b0101000);
        idle(D + 1, 7'b0000010);

        // Multi-hot valid: nothing written, sticky error until reset.
        cyc(7'b0010010, 32'h0BAD, 1'b0, '0);
        idle(5, '0);
        rst = 1'b1;
        idle(1, '0);
        rst = 1'b0;
        idle(3, '0);

        // Random traffic; malformed valids only in the second half.
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 11);
            v = '0;
            if (k < CH) v[k] = 1'b1;
            else if (k >= 10 && i >= 1500) v = CH'($urandom) | 7'b1000001;
            r = CH'($urandom);
            cyc(v, FW'($urandom), 1'($urandom_range(0, 1)), r);
            if (i == 1200) begin
                rst = 1'b1;
                idle(1, '0);
                rst = 1'b0;
            end
        end
        idle(D + 2, '1);
        rst = 1'b1;
        idle(2, '0);
        rst = 1'b0;
        idle(2, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
